// File: rtl/fir_sample_fetch_if.sv
// Bundle of FIFO read-side and MAC tap-stream signals for fir_sample_fetch.
`timescale 1ns/1ps
interface fir_sample_fetch_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 6
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              flush;
  logic              tap_valid;
  logic              tap_ready;
  logic [DATA_W-1:0] tap_data;
  logic [AW-1:0]     tap_idx;
  logic              tap_last;
  logic [15:0]       sample_cnt;

  modport master (
    output fifo_empty, fifo_rd_data, flush, tap_ready,
    input  fifo_rd_en, tap_valid, tap_data, tap_idx, tap_last, sample_cnt
  );

  modport slave (
    input  fifo_empty, fifo_rd_data, flush, tap_ready,
    output fifo_rd_en, tap_valid, tap_data, tap_idx, tap_last, sample_cnt
  );
endinterface

// File: rtl/fir_sample_fetch.sv
// Pops one sample at a time from a FIFO into a circular history and streams
// x[n-k] for k = 0..TAPS-1 to a MAC over a valid/ready handshake.
`timescale 1ns/1ps
module fir_sample_fetch #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 64,
  parameter int AW     = 6
) (
  input  logic             clk_r,
  input  logic             rstn,
  fir_sample_fetch_if.slave io_bus
);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, STREAM} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [DATA_W-1:0] r_hist [TAPS];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_tap_idx;
  logic [DATA_W-1:0] r_tap_data;
  logic [15:0]       r_sample_cnt;
  logic              w_hs;
  logic              w_last;
  logic [AW-1:0]     w_rd_ptr;

  // Reset asserts immediately but releases only after two clk_r edges.
  always_ff @(posedge clk_r or negedge rstn) begin
    if (!rstn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_last   = (r_tap_idx == AW'(TAPS - 1));
  assign w_hs     = (r_state == STREAM) && io_bus.tap_ready;
  assign w_rd_ptr = r_wr_ptr - r_tap_idx - AW'(1);

  always_ff @(posedge clk_r or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!io_bus.fifo_empty) w_next = POP;
      POP:     w_next = CAPTURE;
      CAPTURE: w_next = STREAM;
      STREAM:  if (w_hs && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (io_bus.flush) w_next = IDLE;
  end

  // Flush wipes history and stream state, overriding any capture or handshake.
  always_ff @(posedge clk_r or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
      r_wr_ptr     <= '0;
      r_tap_idx    <= '0;
      r_tap_data   <= '0;
      r_sample_cnt <= '0;
    end else if (io_bus.flush) begin
      for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
      r_wr_ptr     <= '0;
      r_tap_idx    <= '0;
      r_tap_data   <= '0;
      r_sample_cnt <= '0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_hist[r_wr_ptr] <= io_bus.fifo_rd_data;
          r_tap_data       <= io_bus.fifo_rd_data;
          r_tap_idx        <= '0;
          r_sample_cnt     <= r_sample_cnt + 16'd1;
        end
        STREAM: begin
          if (w_hs) begin
            if (w_last) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
              r_tap_idx  <= r_tap_idx + AW'(1);
              r_tap_data <= r_hist[w_rd_ptr];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.fifo_rd_en = (r_state == POP);
  assign io_bus.tap_valid  = (r_state == STREAM);
  assign io_bus.tap_data   = r_tap_data;
  assign io_bus.tap_idx    = r_tap_idx;
  assign io_bus.tap_last   = w_last;
  assign io_bus.sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_fir_sample_fetch.sv
// Self-checking bench: behavioural FIFO plus a newest-first history queue model.
`timescale 1ns/1ps
module tb_fir_sample_fetch;
  localparam int DATA_W = 16;
  localparam int TAPS   = 64;
  localparam int AW     = 6;

  logic clk_r = 1'b0;
  logic rstn  = 1'b0;

  fir_sample_fetch_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  fir_sample_fetch #(.DATA_W(DATA_W), .TAPS(TAPS), .AW(AW)) dut (
    .clk_r  (clk_r),
    .rstn   (rstn),
    .io_bus (bus)
  );

  always #5 clk_r = ~clk_r;

  logic [DATA_W-1:0] fifoQ[$];
  logic [DATA_W-1:0] pend[$];
  logic [DATA_W-1:0] refHist[$];
  int checks = 0;
  int passes = 0;
  int popCount = 0;
  int expPops = 0;
  int refCnt = 0;
  bit rdEnPrev = 0;
  bit rdEnDouble = 0;

  // FIFO read side: data appears the cycle after a pop request.
  always @(posedge clk_r) begin
    logic [DATA_W-1:0] w;
    if (bus.fifo_rd_en) begin
      popCount++;
      if (fifoQ.size() > 0) begin
        w = fifoQ.pop_front();
        bus.fifo_rd_data <= w;
      end
    end
    if (bus.fifo_rd_en && rdEnPrev) rdEnDouble = 1;
    rdEnPrev = bus.fifo_rd_en;
  end

  always @(negedge clk_r) bus.fifo_empty = (fifoQ.size() == 0);

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_r);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] refTap(input int k);
    return (k < refHist.size()) ? refHist[k] : '0;
  endfunction

  task automatic pushSample(input logic [DATA_W-1:0] v);
    fifoQ.push_back(v);
    pend.push_back(v);
  endtask

  task automatic clearModel();
    refHist.delete();
    refCnt = 0;
  endtask

  // abortKind: 0 none, 1 flush at tap abortAt, 2 reset at tap abortAt
  task automatic streamSample(input bit randReady, input int abortAt, input int abortKind);
    int budget;
    int k;
    bit stalled;
    logic [DATA_W-1:0] hd;
    logic [AW-1:0] hi;
    logic hl;
    logic [DATA_W-1:0] v;
    budget = 0;
    while (!bus.fifo_rd_en && budget < 500) begin
      step();
      budget++;
    end
    check("popSeen", bus.fifo_rd_en, 1);
    if (!bus.fifo_rd_en) return;
    expPops++;
    v = pend.pop_front();
    refHist.push_front(v);
    if (refHist.size() > TAPS) void'(refHist.pop_back());
    refCnt++;
    step();
    check("captureQuiet", {bus.tap_valid, bus.fifo_rd_en}, 0);
    step();
    check("latencyValid", bus.tap_valid, 1);
    k = 0;
    stalled = 0;
    budget = 0;
    while (k < TAPS && budget < 3000) begin
      check("validHeld", bus.tap_valid, 1);
      check("noPopInStream", bus.fifo_rd_en, 0);
      if (stalled) begin
        check("stallData", bus.tap_data, hd);
        check("stallIdx", bus.tap_idx, hi);
        check("stallLast", bus.tap_last, hl);
      end
      if (k == abortAt && abortKind == 1) begin
        bus.flush = 1'b1;
        bus.tap_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.tap_ready = 1'b0;
        check("flushValid", bus.tap_valid, 0);
        check("flushCnt", bus.sample_cnt, 0);
        clearModel();
        return;
      end
      if (k == abortAt && abortKind == 2) begin
        rstn = 1'b0;
        #1;
        check("rstValid", bus.tap_valid, 0);
        check("rstData", bus.tap_data, 0);
        check("rstIdx", bus.tap_idx, 0);
        check("rstLast", bus.tap_last, 0);
        check("rstCnt", bus.sample_cnt, 0);
        check("rstRdEn", bus.fifo_rd_en, 0);
        bus.tap_ready = 1'b1;
        repeat (3) step();
        check("rstHeldValid", bus.tap_valid, 0);
        rstn = 1'b1;
        repeat (3) step();
        check("rstRelValid", bus.tap_valid, 0);
        clearModel();
        return;
      end
      bus.tap_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.tap_ready) begin
        check("tapData", bus.tap_data, refTap(k));
        check("tapIdx", bus.tap_idx, k);
        check("tapLast", bus.tap_last, (k == TAPS - 1));
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        hd = bus.tap_data;
        hi = bus.tap_idx;
        hl = bus.tap_last;
      end
      step();
      budget++;
    end
    bus.tap_ready = 1'b0;
    check("handshakeCount", k, TAPS);
    check("validDrop", bus.tap_valid, 0);
    check("sampleCnt", bus.sample_cnt, refCnt & 32'hFFFF);
  endtask

  initial begin
    int seen;
    bus.flush = 1'b0;
    bus.tap_ready = 1'b0;
    repeat (3) step();
    check("rstHoldValid", bus.tap_valid, 0);
    check("rstHoldRdEn", bus.fifo_rd_en, 0);
    check("rstHoldCnt", bus.sample_cnt, 0);
    check("rstHoldData", bus.tap_data, 0);
    rstn = 1'b1;
    repeat (3) step();
    check("postRstValid", bus.tap_valid, 0);
    check("postRstIdx", bus.tap_idx, 0);

    bus.tap_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.fifo_rd_en || bus.tap_valid) seen++;
      step();
    end
    check("emptyIdle", seen, 0);
    bus.tap_ready = 1'b0;

    $display("[TB] first sample");
    pushSample(16'h1234);
    streamSample(1'b0, -1, 0);

    $display("[TB] ordering and wrap, 70 samples");
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    clearModel();
    check("preWrapCnt", bus.sample_cnt, 0);
    for (int i = 1; i <= 70; i++) pushSample(DATA_W'(i));
    for (int i = 0; i < 70; i++) streamSample(1'b0, -1, 0);

    $display("[TB] backpressure with random data");
    for (int i = 0; i < 8; i++) pushSample(DATA_W'($urandom));
    for (int i = 0; i < 8; i++) streamSample(1'b1, -1, 0);

    $display("[TB] flush mid-stream");
    pushSample(DATA_W'($urandom));
    streamSample(1'b0, 20, 1);
    pushSample(16'h00AA);
    streamSample(1'b0, -1, 0);

    $display("[TB] reset mid-stream");
    pushSample(DATA_W'($urandom));
    streamSample(1'b0, 30, 2);
    pushSample(16'h0005);
    streamSample(1'b0, -1, 0);

    repeat (10) step();
    check("popTotal", popCount, expPops);
    check("noDoublePop", rdEnDouble, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fir_sample_fetch.md
FIR_SAMPLE_FETCH -- requirements
Module: fir_sample_fetch

Interface
REQ-001 Parameter: DATA_W, 16, sample width.
REQ-002 Parameter: TAPS, 64, history depth (power of two).
REQ-003 Parameter: AW, 6, history index width (log2 TAPS).
REQ-004 The block SHALL use reset rstn, asynchronous, active-low; clock clk_r.
REQ-005 Port: clk_r  in  1  read-domain clock; all logic rising-edge.
REQ-006 Port: rstn  in  1  async active-low reset.
REQ-007 Port: fifo_empty  in  1  FIFO read-side empty flag.
REQ-008 Port: fifo_rd_en  out  1  FIFO pop request, one cycle per pop.
REQ-009 Port: fifo_rd_data  in  DATA_W  FIFO data, valid the cycle after fifo_rd_en.
REQ-010 Port: flush  in  1  sync clear of history and stream.
REQ-011 Port: tap_valid  out  1  tap sample offered to MAC.
REQ-012 Port: tap_ready  in  1  MAC accepts tap.
REQ-013 Port: tap_data  out  DATA_W  history sample x[n-k].
REQ-014 Port: tap_idx  out  AW  k, 0 = newest.
REQ-015 Port: tap_last  out  1  high with tap_idx = TAPS-1.
REQ-016 Port: sample_cnt  out  16  samples captured since reset/flush, wraps at 65535.

Function
REQ-017 FSM states SHALL be IDLE, POP, CAPTURE, STREAM.
REQ-018 IDLE: !fifo_empty -> POP; else stay IDLE.
REQ-019 POP: fifo_rd_en = 1 for exactly this cycle; -> CAPTURE unconditionally.
REQ-020 fifo_rd_en SHALL be high only in POP, never in two consecutive cycles.
REQ-021 CAPTURE: fifo_rd_data written to hist[wr_ptr]; tap_data loaded with fifo_rd_data (bypass), tap_idx = 0; sample_cnt + 1; -> STREAM.
REQ-022 STREAM: tap_valid = 1; on tap_valid && tap_ready with tap_idx < TAPS-1, tap_idx + 1, tap_data <= hist[(wr_ptr - tap_idx - 1) mod TAPS].
REQ-023 History index arithmetic SHALL be AW-bit modulo TAPS (wrap 0 -> TAPS-1).
REQ-024 tap_data, tap_idx, tap_last SHALL hold stable while tap_valid && !tap_ready.
REQ-025 Handshake with tap_last = 1: wr_ptr + 1 (mod TAPS), tap_valid low next cycle, -> IDLE.
REQ-026 Latency: fifo_rd_en at cycle N -> tap_valid first high at N+2 with the new sample; minimum 67 cycles per sample with tap_ready tied high.
REQ-027 Exactly TAPS handshakes SHALL occur per popped sample; no pop while in CAPTURE or STREAM.
REQ-028 Before TAPS samples captured, unwritten history entries SHALL read 0.
REQ-029 flush (any state): next cycle all history entries 0, wr_ptr 0, sample_cnt 0, tap_valid 0, -> IDLE; flush in POP does not cancel the FIFO pop already issued, captured word is discarded.
REQ-030 flush has priority over every other transition, including a tap_last handshake in the same cycle.
REQ-031 fifo_empty SHALL be ignored outside IDLE.

Reset
REQ-032 rstn low: state IDLE, fifo_rd_en 0, tap_valid 0, tap_data 0, tap_idx 0, tap_last 0, sample_cnt 0, wr_ptr 0, all history 0, immediately (async).
REQ-033 Reset asserted mid-STREAM SHALL abort the stream with no further handshakes; release behaves as fresh start.
REQ-034 Reset deassertion SHALL be synchronised internally to clk_r (two-flop release).

Verification
REQ-035 First sample: reset, push 0x1234, tap_ready = 1 -> fifo_rd_en one pulse; taps k=0 0x1234, k=1..63 0x0000; tap_last only at k=63; sample_cnt = 1.
REQ-036 Ordering/wrap: push 1..70 -> for sample 70, k=0..63 yield 70..7; wr_ptr wrapped once; sample_cnt = 70.
REQ-037 Backpressure: tap_ready toggled pseudo-randomly -> tap outputs stable during stalls, exactly 64 handshakes per sample, no extra pops.
REQ-038 Empty: fifo_empty held high 100 cycles -> fifo_rd_en never asserted, tap_valid stays 0.
REQ-039 Flush mid-stream at tap_idx = 20, then push 0x00AA -> next stream 0x00AA then 63 zeros; sample_cnt = 1.
REQ-040 Reset mid-stream at tap_idx = 30 -> all outputs 0 same cycle; after release push 0x0005 -> 0x0005 then 63 zeros.
